// File: rtl/l2_mem_responder_if.sv
// Request/response bundle between the cache miss handler (master) and the L2 backing store (slave).
// Handshake: a request transfers on a rising edge where l2_mem_en and l2_mem_ready are both high;
// the master holds en/wr_en/addr/wr_data stable until that edge, and reads finish with one l2_mem_rd_valid cycle.
interface l2_mem_responder_if;
   logic        l2_mem_en;
   logic        l2_mem_wr_en;
   logic [31:0] l2_mem_access_addr;
   logic [31:0] l2_mem_wr_data;
   logic        l2_mem_ready;
   logic [31:0] l2_mem_rd_data;
   logic        l2_mem_rd_valid;
   logic        l2_mem_addr_err;

   modport master (
      output l2_mem_en, l2_mem_wr_en, l2_mem_access_addr, l2_mem_wr_data,
      input  l2_mem_ready, l2_mem_rd_data, l2_mem_rd_valid, l2_mem_addr_err
   );

   modport slave (
      input  l2_mem_en, l2_mem_wr_en, l2_mem_access_addr, l2_mem_wr_data,
      output l2_mem_ready, l2_mem_rd_data, l2_mem_rd_valid, l2_mem_addr_err
   );
endinterface

// File: rtl/l2_mem_responder.sv
// Word-addressed L2 backing store: one request in flight, configurable read latency and write recovery.
// Writes commit on the accepting edge; reads sample the array on the last wait edge.
module l2_mem_responder #(
   parameter int MEM_WORDS  = 4096,
   parameter int RD_LATENCY = 2,
   parameter int WR_RECOVER = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   l2_mem_responder_if.slave  l2_mem,
   output logic [1:0]         state_o
);
   localparam int IDX_W   = $clog2(MEM_WORDS);
   localparam int MAX_CNT = (RD_LATENCY > WR_RECOVER) ? RD_LATENCY : WR_RECOVER;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'((WR_RECOVER > 0) ? WR_RECOVER - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_RD_RESP = 2'd2,
      S_WR_BUSY = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             oor_q, oor_d;
   logic [31:0]      rd_data_q, rd_data_d;
   logic             wr_err_q, wr_err_d;
   logic             live_q;
   logic [31:0]      mem_q [MEM_WORDS];

   logic             ready;
   logic             accept;
   logic             in_range;
   logic             mem_we;
   logic [IDX_W-1:0] idx_in;
   logic             unused_addr_bits;

   assign idx_in           = l2_mem.l2_mem_access_addr[IDX_W+1:2];
   assign in_range         = (l2_mem.l2_mem_access_addr[31:IDX_W+2] == '0);
   assign unused_addr_bits = ^l2_mem.l2_mem_access_addr[1:0];
   assign accept           = l2_mem.l2_mem_en & ready;

   // live_q holds ready low for the first cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         oor_q     <= 1'b0;
         rd_data_q <= '0;
         wr_err_q  <= 1'b0;
         live_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         oor_q     <= oor_d;
         rd_data_q <= rd_data_d;
         wr_err_q  <= wr_err_d;
         live_q    <= 1'b1;
      end
   end

   // The array is never reset so that contents survive a mid-run reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[idx_in] <= l2_mem.l2_mem_wr_data;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      oor_d     = oor_q;
      rd_data_d = rd_data_q;
      wr_err_d  = 1'b0;
      mem_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               idx_d = idx_in;
               oor_d = ~in_range;
               if (l2_mem.l2_mem_wr_en) begin
                  mem_we   = in_range;
                  wr_err_d = ~in_range;
                  if (WR_RECOVER > 0) begin
                     state_d = S_WR_BUSY;
                     cnt_d   = WR_LOAD;
                  end
               end else begin
                  state_d = S_RD_WAIT;
                  cnt_d   = RD_LOAD;
               end
            end
         end
         S_RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d   = S_RD_RESP;
               rd_data_d = oor_q ? 32'h0 : mem_q[idx_q];
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RD_RESP: state_d = S_IDLE;
         S_WR_BUSY: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready                  = live_q && (state_q == S_IDLE);
      l2_mem.l2_mem_ready    = ready;
      l2_mem.l2_mem_rd_data  = rd_data_q;
      l2_mem.l2_mem_rd_valid = (state_q == S_RD_RESP);
      l2_mem.l2_mem_addr_err = wr_err_q | ((state_q == S_RD_RESP) & oor_q);
      state_o                = state_q;
   end
endmodule
